// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter that shares the register file write port between the ALU (A) and load (B) writeback.
// The winning write is registered into the output stage; writes to register 0 are consumed but dropped.
module regfile_write_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic                  Stall,
  input  logic                  AReq,
  input  logic [ADDR_WIDTH-1:0] AAddr,
  input  logic [DATA_WIDTH-1:0] AData,
  output logic                  AGrant,
  input  logic                  BReq,
  input  logic [ADDR_WIDTH-1:0] BAddr,
  input  logic [DATA_WIDTH-1:0] BData,
  output logic                  BGrant,
  output logic                  RegWrite,
  output logic [ADDR_WIDTH-1:0] WriteRegister,
  output logic [DATA_WIDTH-1:0] WriteData,
  output logic [CNT_WIDTH-1:0]  WriteCount
);

  typedef enum logic {
    PORT_A = 1'b0,
    PORT_B = 1'b1
  } port_e;

  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  port_e                 lastPort;
  logic                  anyGrant;
  logic [ADDR_WIDTH-1:0] winAddr;
  logic [DATA_WIDTH-1:0] winData;

  // On a tie the port that did not win last time is served, so neither side starves
  always_comb begin
    AGrant = 1'b0;
    BGrant = 1'b0;
    if (!Reset && !Stall) begin
      if (AReq && BReq) begin
        AGrant = (lastPort == PORT_B);
        BGrant = (lastPort == PORT_A);
      end else begin
        AGrant = AReq;
        BGrant = BReq;
      end
    end
  end

  assign anyGrant = AGrant | BGrant;
  assign winAddr  = AGrant ? AAddr : BAddr;
  assign winData  = AGrant ? AData : BData;

  // A register-0 transfer still moves the pointer but leaves the output stage and count untouched
  always_ff @(posedge Clk) begin
    if (Reset) begin
      lastPort      <= PORT_B;
      RegWrite      <= 1'b0;
      WriteRegister <= '0;
      WriteData     <= '0;
      WriteCount    <= '0;
    end else begin
      RegWrite <= 1'b0;
      if (anyGrant) begin
        lastPort <= AGrant ? PORT_A : PORT_B;
        if (winAddr != '0) begin
          RegWrite      <= 1'b1;
          WriteRegister <= winAddr;
          WriteData     <= winData;
          if (WriteCount != CNT_MAX) begin
            WriteCount <= WriteCount + CNT_ONE;
          end
        end
      end
    end
  end

endmodule
